// File: rtl/cpu_pkg.sv
// Shared opcode, ALU and instruction-field definitions for the 16-bit CPU decode path.
// Latency: n/a (types, constants and a pure combinational decode helper).
// Backpressure: n/a.
package cpu_pkg;

  // Opcodes, held in instruction bits [15:12]
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;

  // ALU function encodings, as seen on alufuncE
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_e;

  // Instruction field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    alu_e       alufunc;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic       uses_rs;    // reads rs1/rs2 from the register file
    logic       writes_rd;  // issues to execute and claims rd
    logic       is_imm;     // operands come from the immediate, not the register file
    logic       legal;      // opcode is defined (NOP counts as legal)
  } dec_t;

  function automatic dec_t decode(input logic [15:0] instr);
    dec_t d;
    d           = '0;
    d.alufunc   = ALU_ADD;
    d.rd        = instr[RD_MSB:RD_LSB];
    d.rs1       = instr[RS1_MSB:RS1_LSB];
    d.rs2       = instr[RS2_MSB:RS2_LSB];
    d.imm       = instr[IMM_MSB:IMM_LSB];
    d.legal     = 1'b1;
    case (instr[OP_MSB:OP_LSB])
      OP_NOP: ;
      OP_ADD: begin d.alufunc = ALU_ADD; d.uses_rs = 1'b1; d.writes_rd = 1'b1; end
      OP_SUB: begin d.alufunc = ALU_SUB; d.uses_rs = 1'b1; d.writes_rd = 1'b1; end
      OP_AND: begin d.alufunc = ALU_AND; d.uses_rs = 1'b1; d.writes_rd = 1'b1; end
      OP_OR:  begin d.alufunc = ALU_OR;  d.uses_rs = 1'b1; d.writes_rd = 1'b1; end
      OP_LDI: begin d.alufunc = ALU_ADD; d.is_imm  = 1'b1; d.writes_rd = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: 2 async read ports, 1 write port, R0 reads zero, write-through bypass.
// Latency: reads combinational; writes land at the next rising edge (visible same cycle via bypass).
// Backpressure: none, always accepts writes.
// Ports: i_clk, i_rst_n (async active-low), i_we/i_waddr/i_wdata write port,
//        i_raddr1/o_rdata1 and i_raddr2/o_rdata2 read ports.
module reg_file
  import cpu_pkg::*;
#(
  parameter int NREG = 16,
  parameter int DW   = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  output logic [DW-1:0] o_rdata1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata2
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // R0 is forced to zero on read; a same-cycle write to the read address is forwarded.
  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    if (a == '0)                   return '0;
    else if (i_we && i_waddr == a) return i_wdata;
    else                           return r_mem[a];
  endfunction

  always_comb begin
    o_rdata1 = rd_port(i_raddr1);
    o_rdata2 = rd_port(i_raddr2);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes one instruction per cycle, reads operands, tracks RAW hazards, launches D/E register.
// Latency: 1 cycle from accept to E outputs.
// Backpressure: instr_readyD drops on stallE or an unresolved RAW hazard; flushD always consumes.
// Ports: clk, reset_n (async active-low); fetch side instrD/instr_validD/instr_readyD/flushD;
//        stallE from execute; writeback wb_en/wb_add/wb_data;
//        E side alufuncE/srcdataE1/srcdataE2/destaddE/validE/illegalE.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int NREG = 16,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] instrD,
  input  logic          instr_validD,
  output logic          instr_readyD,
  input  logic          flushD,
  input  logic          stallE,
  input  logic          wb_en,
  input  logic [3:0]    wb_add,
  input  logic [DW-1:0] wb_data,
  output logic [1:0]    alufuncE,
  output logic [DW-1:0] srcdataE1,
  output logic [DW-1:0] srcdataE2,
  output logic [3:0]    destaddE,
  output logic          validE,
  output logic          illegalE
);

  dec_t            w_dec;
  logic [DW-1:0]   w_rd1;
  logic [DW-1:0]   w_rd2;
  logic [DW-1:0]   w_src1;
  logic [DW-1:0]   w_src2;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_pend_eff;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_hazard;
  logic            w_take;
  logic            w_issue;
  logic            w_illegal;

  logic [NREG-1:0] r_pend;
  logic [1:0]      r_alufunc;
  logic [DW-1:0]   r_src1;
  logic [DW-1:0]   r_src2;
  logic [3:0]      r_dest;
  logic            r_valid;
  logic            r_illegal;

  reg_file #(.NREG(NREG), .DW(DW), .AW(4)) u_rf (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_we     (wb_en),
    .i_waddr  (wb_add),
    .i_wdata  (wb_data),
    .i_raddr1 (w_dec.rs1),
    .o_rdata1 (w_rd1),
    .i_raddr2 (w_dec.rs2),
    .o_rdata2 (w_rd2)
  );

  always_comb begin
    w_dec = decode(instrD[15:0]);

    w_clr = '0;
    if (wb_en) w_clr[wb_add] = 1'b1;

    // A writeback arriving this cycle resolves the hazard; the bypass supplies its data.
    w_pend_eff = r_pend & ~w_clr;
    w_hazard   = w_dec.uses_rs &
                 (((w_dec.rs1 != 4'd0) & w_pend_eff[w_dec.rs1]) |
                  ((w_dec.rs2 != 4'd0) & w_pend_eff[w_dec.rs2]));

    // Flush consumes regardless of stall/hazard so fetch drops the instruction.
    instr_readyD = instr_validD & (flushD | (~stallE & ~w_hazard));
    w_take       = instr_validD & ~flushD & ~stallE & ~w_hazard;
    w_issue      = w_take & w_dec.writes_rd;
    w_illegal    = w_take & ~w_dec.legal;

    w_set = '0;
    if (w_issue) w_set[w_dec.rd] = 1'b1;
    // Set after clear so a same-cycle set wins; R0 never tracked.
    w_pend_nxt    = (r_pend & ~w_clr) | w_set;
    w_pend_nxt[0] = 1'b0;

    w_src1 = w_dec.is_imm ? '0 : w_rd1;
    w_src2 = w_dec.is_imm ? {{(DW-8){1'b0}}, w_dec.imm} : w_rd2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= '0;
      r_alufunc <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_dest    <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (stallE) begin
        r_illegal <= 1'b0;
      end else begin
        r_illegal <= w_illegal;
        if (w_issue) begin
          r_alufunc <= w_dec.alufunc;
          r_src1    <= w_src1;
          r_src2    <= w_src2;
          r_dest    <= w_dec.rd;
          r_valid   <= 1'b1;
        end else begin
          r_alufunc <= '0;
          r_src1    <= '0;
          r_src2    <= '0;
          r_dest    <= '0;
          r_valid   <= 1'b0;
        end
      end
    end
  end

  assign alufuncE  = r_alufunc;
  assign srcdataE1 = r_src1;
  assign srcdataE2 = r_src2;
  assign destaddE  = r_dest;
  assign validE    = r_valid;
  assign illegalE  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios then random traffic, scoreboarded against a reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instrD;
  logic        instr_validD, instr_readyD, flushD, stallE, wb_en;
  logic [3:0]  wb_add;
  logic [15:0] wb_data;
  logic [1:0]  alufuncE;
  logic [15:0] srcdataE1, srcdataE2;
  logic [3:0]  destaddE;
  logic        validE, illegalE;

  always #5 clk = ~clk;

  decode_stage #(.NREG(16), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n), .instrD(instrD), .instr_validD(instr_validD),
    .instr_readyD(instr_readyD), .flushD(flushD), .stallE(stallE), .wb_en(wb_en),
    .wb_add(wb_add), .wb_data(wb_data), .alufuncE(alufuncE), .srcdataE1(srcdataE1),
    .srcdataE2(srcdataE2), .destaddE(destaddE), .validE(validE), .illegalE(illegalE)
  );

  typedef struct {
    logic        v;
    logic        ill;
    logic [1:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  d;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_regs[16];
  logic [15:0] m_pend;
  bit          cyc_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pend = '0;
    q.delete();
  endtask

  // One fetch cycle: drive inputs, predict readiness, and queue the expected E result.
  task automatic step(input logic [15:0] ins, input bit v, input bit fl, input bit st,
                      input bit we, input logic [3:0] wa, input logic [15:0] wd);
    logic [3:0] op, rd, r1, r2;
    bit alu, ldi, ill, haz, rdy, take;
    exp_t e;
    @(negedge clk);
    instrD = ins; instr_validD = v; flushD = fl; stallE = st;
    wb_en = we; wb_add = wa; wb_data = wd;
    op = ins[15:12]; rd = ins[11:8]; r1 = ins[7:4]; r2 = ins[3:0];
    // Writeback takes effect before this cycle's reads and before this cycle's claim on rd.
    if (we) begin
      m_pend[wa] = 1'b0;
      if (wa != 4'd0) m_regs[wa] = wd;
    end
    alu  = (op >= 4'd1) && (op <= 4'd4);
    ldi  = (op == 4'd5);
    ill  = (op >= 4'd6);
    haz  = alu && ((r1 != 0 && m_pend[r1]) || (r2 != 0 && m_pend[r2]));
    rdy  = v && (fl || (!st && !haz));
    take = v && !fl && !st && !haz;
    #1;
    chk("instr_readyD", 64'(instr_readyD), 64'(rdy));
    if (take && (alu || ldi)) begin
      e.v = 1'b1; e.ill = 1'b0; e.d = rd;
      e.f = ldi ? 2'd0 : 2'(op - 4'd1);
      e.a = ldi ? 16'h0 : m_regs[r1];
      e.b = ldi ? {8'h00, ins[7:0]} : m_regs[r2];
      q.push_back(e);
      if (rd != 0) m_pend[rd] = 1'b1;
    end else if (take && ill) begin
      e.v = 1'b0; e.ill = 1'b1; e.f = 2'd0; e.a = 16'h0; e.b = 16'h0; e.d = 4'd0;
      q.push_back(e);
    end
    cyc_stall = st;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    instr_validD = 1'b0; flushD = 1'b0; stallE = 1'b0; wb_en = 1'b0;
    model_reset();
    cyc_stall = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [38:0] e_vec();
    return {validE, alufuncE, destaddE, srcdataE1, srcdataE2};
  endfunction

  // Monitor: pops an expectation whenever the E register presents a result.
  logic [38:0] snap = '0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        chk("reset_outputs", 64'({illegalE, e_vec()}), 64'h0);
      end else if (cyc_stall) begin
        chk("stall_hold", 64'(e_vec()), 64'(snap));
        chk("stall_illegalE", 64'(illegalE), 64'h0);
      end else if (validE || illegalE) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got valid=%0b illegal=%0b expected none", validE, illegalE);
        end else begin
          e = q.pop_front();
          chk("e_result", 64'({illegalE, e_vec()}), 64'({e.ill, e.v, e.f, e.d, e.a, e.b}));
        end
      end else begin
        chk("bubble", 64'(e_vec()), 64'h0);
      end
      snap = e_vec();
    end
  end

  initial begin
    logic [3:0]  op, wa;
    logic [15:0] ins;
    bit          we;
    reset_n = 1'b0; instrD = '0; instr_validD = 1'b0; flushD = 1'b0; stallE = 1'b0;
    wb_en = 1'b0; wb_add = '0; wb_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Register load and a dependent-free ADD
    step(16'h0, 0, 0, 0, 1, 4'd1, 16'h1234);
    step(16'h0, 0, 0, 0, 1, 4'd2, 16'h0F0F);
    step(16'h1312, 1, 0, 0, 0, 4'd0, 16'h0);          // ADD R3,R1,R2
    // LDI then dependent ADD held until writeback of R4
    step(16'h54A5, 1, 0, 0, 0, 4'd0, 16'h0);          // LDI R4,0xA5
    step(16'h1544, 1, 0, 0, 0, 4'd0, 16'h0);          // ADD R5,R4,R4 (hazard)
    step(16'h1544, 1, 0, 0, 0, 4'd0, 16'h0);
    step(16'h1544, 1, 0, 0, 1, 4'd4, 16'h00A5);       // resolved by bypass
    // Execute stall for three cycles
    step(16'h2612, 1, 0, 1, 0, 4'd0, 16'h0);          // SUB R6,R1,R2
    step(16'h2612, 1, 0, 1, 0, 4'd0, 16'h0);
    step(16'h2612, 1, 0, 1, 0, 4'd0, 16'h0);
    step(16'h2612, 1, 0, 0, 0, 4'd0, 16'h0);
    // Illegal opcode
    step(16'hF123, 1, 0, 0, 0, 4'd0, 16'h0);
    // Flushed AND must not claim R7
    step(16'h3712, 1, 1, 0, 0, 4'd0, 16'h0);
    step(16'h1870, 1, 0, 0, 0, 4'd0, 16'h0);          // ADD R8,R7,R0
    idle(2);
    // Reset while R4 is pending and a dependent ADD is stalled
    step(16'h54A5, 1, 0, 0, 0, 4'd0, 16'h0);
    step(16'h1544, 1, 0, 0, 0, 4'd0, 16'h0);
    do_reset(1);
    step(16'h1544, 1, 0, 0, 0, 4'd0, 16'h0);          // issues with 0/0
    idle(1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      op  = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
      ins = {op, 12'($urandom)};
      we  = 1'b0; wa = 4'd0;
      if (m_pend != 16'h0 && $urandom_range(0, 9) < 4) begin
        we = 1'b1;
        do wa = 4'($urandom_range(1, 15)); while (!m_pend[wa]);
      end else if ($urandom_range(0, 9) < 2) begin
        we = 1'b1;
        wa = 4'($urandom_range(0, 15));
      end
      step(ins, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 1,
           $urandom_range(0, 9) < 2, we, wa, 16'($urandom));
    end

    idle(3);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
